// File: rtl/power_pkg.sv
// Shared types and helpers for the iterative integer power units.
package power_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result width that holds (2^w-1)^max_exp without truncation.
   function automatic int calc_y_w(input int w, input int max_exp);
      return w * max_exp;
   endfunction

endpackage

// File: rtl/power_seq.sv
// Iterative y = x^e behind a valid/ready handshake: one multiply per cycle
// in MUL, result and error flag held in DONE until accepted.
module power_seq
   import power_pkg::*;
#(
   parameter  int W       = 7,
   parameter  int MAX_EXP = 3,
   parameter  int EXP_W   = 3,
   localparam int Y_W     = calc_y_w(W, MAX_EXP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x,
   input  logic [EXP_W-1:0] e,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Y_W-1:0]   y,
   output logic             err
);

   state_t           state, state_nxt;
   logic [Y_W-1:0]   acc, acc_nxt;
   logic [W-1:0]     xr, xr_nxt;
   logic [EXP_W-1:0] rem, rem_nxt;
   logic             err_flag, err_nxt;
   logic             accept;
   logic             bad_exp;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign y         = acc;
   assign err       = err_flag;

   assign accept  = in_valid && in_ready;
   assign bad_exp = 32'(e) > MAX_EXP;

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      xr_nxt    = xr;
      rem_nxt   = rem;
      err_nxt   = err_flag;
      case (state)
         IDLE: begin
            if (accept) begin
               xr_nxt = x;
               if (bad_exp) begin
                  acc_nxt   = '0;
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
               end else if (e == '0) begin
                  acc_nxt   = Y_W'(1);
                  state_nxt = DONE;
               end else if (e == EXP_W'(1)) begin
                  acc_nxt   = Y_W'(x);
                  state_nxt = DONE;
               end else begin
                  acc_nxt   = Y_W'(x);
                  rem_nxt   = e - EXP_W'(1);
                  state_nxt = MUL;
               end
            end
         end
         MUL: begin
            // Truncation is lossless for legal exponents by choice of Y_W.
            acc_nxt = acc * Y_W'(xr);
            rem_nxt = rem - EXP_W'(1);
            if (rem == EXP_W'(1))
               state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) begin
               err_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         xr       <= '0;
         rem      <= '0;
         err_flag <= 1'b0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         xr       <= xr_nxt;
         rem      <= rem_nxt;
         err_flag <= err_nxt;
      end
   end

endmodule

// File: tb/tb_power_seq.sv
// Directed bench for power_seq: latency, values, error code, backpressure, reset.
module tb_power_seq;

   localparam int W       = 7;
   localparam int MAX_EXP = 3;
   localparam int EXP_W   = 3;
   localparam int Y_W     = W * MAX_EXP;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     x;
   logic [EXP_W-1:0] e;
   logic             out_valid;
   logic             out_ready;
   logic [Y_W-1:0]   y;
   logic             err;

   int n_cmp = 0;
   int n_bad = 0;

   power_seq #(.W(W), .MAX_EXP(MAX_EXP), .EXP_W(EXP_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .e         (e),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one request and follow it to DONE; lat counts the accept edge.
   task automatic run_txn(input string tag, input int xv, input int ev,
                          input int lat, input int exp_y, input int exp_err);
      chk({tag, ".in_ready"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      x        = W'(xv);
      e        = EXP_W'(ev);
      tick();
      in_valid = 1'b0;
      x        = '0;
      e        = '0;
      for (int k = 1; k < lat; k++) begin
         chk({tag, ".early"}, 32'(out_valid), 0);
         tick();
      end
      chk({tag, ".out_valid"}, 32'(out_valid), 1);
      chk({tag, ".y"}, 32'(y), 32'(exp_y));
      chk({tag, ".err"}, 32'(err), 32'(exp_err));
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      chk({tag, ".drop"}, 32'(out_valid), 0);
      chk({tag, ".err_clr"}, 32'(err), 0);
      chk({tag, ".idle"}, 32'(in_ready), 1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      x         = '0;
      e         = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst.in_ready", 32'(in_ready), 1);
      chk("rst.out_valid", 32'(out_valid), 0);
      chk("rst.y", 32'(y), 0);
      chk("rst.err", 32'(err), 0);
      rst = 1'b0;

      // x toggling without in_valid must not start anything
      for (int k = 0; k < 3; k++) begin
         x = W'(k * 37 + 5);
         e = EXP_W'(k);
         tick();
         chk("noreq.out_valid", 32'(out_valid), 0);
         chk("noreq.y", 32'(y), 0);
      end
      x = '0;
      e = '0;

      run_txn("cube3", 3, 3, 3, 27, 0);        drain("cube3");
      run_txn("cube5", 5, 3, 3, 125, 0);       drain("cube5");
      run_txn("cube7", 7, 3, 3, 343, 0);       drain("cube7");
      run_txn("cube1", 1, 3, 3, 1, 0);         drain("cube1");
      run_txn("cube127", 127, 3, 3, 2048383, 0); drain("cube127");
      run_txn("sq127", 127, 2, 2, 16129, 0);   drain("sq127");
      run_txn("e0", 99, 0, 1, 1, 0);           drain("e0");
      run_txn("e1", 42, 1, 1, 42, 0);          drain("e1");
      run_txn("ebad", 3, 5, 1, 0, 1);          drain("ebad");
      run_txn("after_bad", 3, 2, 2, 9, 0);     drain("after_bad");

      // Backpressure: result held, new requests ignored
      out_ready = 1'b0;
      run_txn("bp", 5, 3, 3, 125, 0);
      in_valid = 1'b1;
      x        = W'(2);
      e        = EXP_W'(2);
      for (int k = 0; k < 6; k++) begin
         chk("bp.in_ready", 32'(in_ready), 0);
         tick();
         chk("bp.hold_valid", 32'(out_valid), 1);
         chk("bp.hold_y", 32'(y), 125);
      end
      in_valid = 1'b0;
      drain("bp");
      run_txn("bp_next", 2, 2, 2, 4, 0);       drain("bp_next");

      // Reset in the second MUL cycle discards the partial product
      chk("rmid.in_ready", 32'(in_ready), 1);
      in_valid = 1'b1;
      x        = W'(7);
      e        = EXP_W'(3);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rmid.out_valid", 32'(out_valid), 0);
      chk("rmid.y", 32'(y), 0);
      chk("rmid.in_ready", 32'(in_ready), 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rmid.no_stale", 32'(out_valid), 0);
      end
      run_txn("rmid_fresh", 3, 2, 2, 9, 0);    drain("rmid_fresh");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/power_seq.md
# power_seq

Sequential, parametrised integer power unit computing y = x^e for an unsigned W-bit operand and a runtime exponent e in 0..MAX_EXP. It generalises the fixed combinational cube: the exponent is selectable per transaction and the result comes from an iterative multiply loop. The loop sits behind a valid/ready handshake, so it can sit in the datapath pipeline without a wide combinational multiplier chain.

## Interface
- W, default 7: operand width.
- MAX_EXP, default 3: largest legal exponent.
- EXP_W, default 3: exponent port width; codes above MAX_EXP are errors.
- Y_W (localparam) = W*MAX_EXP, default 21: result width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/exponent valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- x  in  W  unsigned operand.
- e  in  EXP_W  unsigned exponent.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- y  out  Y_W  unsigned result, zero-extended.
- err  out  1  qualified by out_valid; set when e > MAX_EXP.

## Operation
- States: IDLE, MUL, DONE. Reset state is IDLE. Reset values are in_ready=1, out_valid=0, y=0, err=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register x into xr.
  - If e > MAX_EXP: acc←0, err←1, go to DONE.
  - Else if e==0: acc←1, go to DONE.
  - Else if e==1: acc←x, go to DONE.
  - Else: acc←x, rem←e-1, go to MUL.
- MUL:
  - Each cycle: acc←(acc*xr) truncated to Y_W bits, rem←rem-1.
  - When rem==1 before the update, go to DONE.
  - Truncation never loses bits for legal e, because (2^W-1)^MAX_EXP < 2^Y_W.
- DONE:
  - out_valid=1 and y=acc. y and err are held stable while out_ready is low.
  - On out_ready, go to IDLE. out_valid drops and err clears.
  - y keeps its last value, but it is don't-care while out_valid=0.
- Inputs while busy: in_valid in MUL or DONE is ignored; x and e are not sampled. Upstream must hold its request.
- No overlap: a new transaction is accepted only in IDLE, so there is at least one idle cycle between results.
- Reset mid-operation: rst in any state forces IDLE with reset output values. A partial result is discarded and never presented.
- No input registering in IDLE without a handshake. A toggling x while in_valid=0 has no effect.

## Timing
- Let T be the accept edge.
- Latency to out_valid rising: 1 edge after T for e ∈ {0, 1, error}; e edges after T for 2 ≤ e ≤ MAX_EXP.
- A DONE handshake at edge D makes in_ready=1 from D onward. The next accept is at D+1 at the earliest.
- Throughput with out_ready tied high: one result per max(e,1)+1 cycles.
- rst has priority over every handshake in the same cycle.
- out_valid is never combinationally dependent on out_ready.

## Structure
- Shared package power_pkg holds:
  - state enum {IDLE, MUL, DONE};
  - a function computing Y_W from W and MAX_EXP, for reuse by sibling units.
- No sub-module. The single W×Y_W multiply is inferred inline.
- Target size is about 150 lines of RTL.
- The counter rem is EXP_W bits wide.

## Test plan
- x=3, e=3, out_ready=1 → out_valid 3 edges after accept, y=27, err=0. Repeat with x=5→125, x=7→343, x=1→1.
- x=127, e=3 → y=2048383, no truncation. x=127, e=2 → y=16129 after 2 edges.
- e=0 with x=99 → y=1 one edge after accept. e=1 with x=42 → y=42 one edge after accept.
- e=5 (> MAX_EXP) with x=3 → one edge later out_valid=1, err=1, y=0. The next legal transaction has err=0.
- Backpressure: x=5, e=3, out_ready held low for 6 cycles → y=125 stable and out_valid high throughout. in_valid with x=2 pulsed during this time is ignored (in_ready=0). After the release, the next accept yields the new result.
- Reset during MUL (x=7, e=3, rst at the second MUL cycle) → next edge: state IDLE, out_valid=0, y=0, in_ready=1. No stale result appears. A fresh x=3, e=2 then gives 9.
